// File: rtl/mod_index_sequencer_if.sv
// Coordinate-stream bundle between the index sequencer and its controller/consumer.
// The master side is the sequencer; the slave side drives start/mode/ready.
interface mod_index_sequencer_if #(
  parameter int W = 3
) ();
  logic         start;
  logic         mode;
  logic         ready;
  logic         valid;
  logic [W-1:0] i_idx;
  logic [W-1:0] j_idx;
  logic [W-1:0] i_off;
  logic [W-1:0] i_inc;
  logic [W-1:0] i_dec;
  logic         last;
  logic         busy;
  logic         done;

  modport master (
    input  start, mode, ready,
    output valid, i_idx, j_idx, i_off, i_inc, i_dec, last, busy, done
  );

  modport slave (
    output start, mode, ready,
    input  valid, i_idx, j_idx, i_off, i_inc, i_dec, last, busy, done
  );
endinterface

// File: rtl/mod_index_sequencer.sv
// Walks every (i, j) of an N x N lane grid, one coordinate per valid/ready handshake,
// with registered mod-N neighbours of i (i+OFFSET, i+1, i-1).
module mod_index_sequencer #(
  parameter int N      = 5,
  parameter int W      = 3,
  parameter int OFFSET = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mod_index_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [W-1:0] OFF_C    = W'(OFFSET);
  localparam logic [W-1:0] ONE_C    = W'(1);
  localparam logic [W:0]   N_C      = (W + 1)'(N);

  // Operands are both < N, so one conditional subtraction reduces the sum mod N.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] k);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, k};
    if (s >= N_C) s = s - N_C;
    return s[W-1:0];
  endfunction

  state_t       state_q, state_d;
  logic         mode_q, mode_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         last_q, last_d;
  logic [W-1:0] i_q, i_d;
  logic [W-1:0] j_q, j_d;
  logic [W-1:0] ioff_q, ioff_d;
  logic [W-1:0] iinc_q, iinc_d;
  logic [W-1:0] idec_q, idec_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      ioff_q  <= OFF_C;
      iinc_q  <= ONE_C;
      idec_q  <= LAST_IDX;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
      i_q     <= i_d;
      j_q     <= j_d;
      ioff_q  <= ioff_d;
      iinc_q  <= iinc_d;
      idec_q  <= idec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    last_d  = last_q;
    i_d     = i_q;
    j_d     = j_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          i_d     = '0;
          j_d     = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          last_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (valid_q && bus.ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            if (!mode_q) begin
              i_d = mod_add(i_q, ONE_C);
              if (i_q == LAST_IDX) j_d = mod_add(j_q, ONE_C);
            end else begin
              j_d = mod_add(j_q, ONE_C);
              if (j_q == LAST_IDX) i_d = mod_add(i_q, ONE_C);
            end
            last_d = (i_d == LAST_IDX) && (j_d == LAST_IDX);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Neighbours follow the next-state i so they register alongside it.
    ioff_d = mod_add(i_d, OFF_C);
    iinc_d = mod_add(i_d, ONE_C);
    idec_d = mod_add(i_d, LAST_IDX);
  end

  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.last  = last_q;
  assign bus.i_idx = i_q;
  assign bus.j_idx = j_q;
  assign bus.i_off = ioff_q;
  assign bus.i_inc = iinc_q;
  assign bus.i_dec = idec_q;

endmodule
